// File: rtl/mul_arb.sv
// Round-robin arbiter that time-shares one external 8x8 shift-add multiplier between N requesters.
// Each grant drives LOAD -> RUN -> DONE; a watchdog bounds RUN if the multiplier never finishes.
module mul_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned WDOG = 15
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   a_in,
  input  logic [8*N-1:0]   b_in,
  output logic [N-1:0]     done,
  output logic             err,
  output logic [16:0]      result,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic [7:0]       m_a,
  output logic [7:0]       m_b,
  output logic             m_start,
  input  logic [16:0]      m_o,
  input  logic             m_fin
);

  localparam int unsigned WW = $clog2(WDOG);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [7:0]     a_q, a_d;
  logic [7:0]     b_q, b_d;
  logic [16:0]    res_q, res_d;
  logic           err_q, err_d;
  logic [WW-1:0]  wd_q, wd_d;

  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;

  // Search starts at ptr, so the requester served last has the lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'((32'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = sel;
          a_d     = a_in[{sel, 3'b000} +: 8];
          b_d     = b_in[{sel, 3'b000} +: 8];
          state_d = StLoad;
        end
      end
      StLoad: begin
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        // A finishing multiplier wins over a coincident watchdog expiry.
        if (m_fin) begin
          res_d   = m_o;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (wd_q == WW'(WDOG - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone: begin
        ptr_d   = (gnt_q == IDW'(N - 1)) ? '0 : gnt_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == StDone) done[gnt_q] = 1'b1;
  end

  assign err     = err_q;
  assign result  = res_q;
  assign gnt_id  = gnt_q;
  assign busy    = (state_q != StIdle);
  assign m_a     = a_q;
  assign m_b     = b_q;
  assign m_start = (state_q == StLoad);

endmodule

// File: tb/tb_mul_arb.sv
// Randomized scoreboard bench for mul_arb: a transaction-level arbiter model predicts every done
// pulse (requester, product, err, cycle) and a monitor checks what the DUT presents.
module tb_mul_arb;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int WDOG = 15;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [8*N-1:0]   a_in = '0;
  logic [8*N-1:0]   b_in = '0;
  logic [N-1:0]     done;
  logic             err;
  logic [16:0]      result;
  logic [IDW-1:0]   gnt_id;
  logic             busy;
  logic [7:0]       m_a, m_b;
  logic             m_start;
  logic [16:0]      m_o;
  logic             m_fin;

  always #5 ck = ~ck;

  mul_arb #(.N(N), .IDW(IDW), .WDOG(WDOG)) dut (
    .ck(ck), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .done(done), .err(err),
    .result(result), .gnt_id(gnt_id), .busy(busy), .m_a(m_a), .m_b(m_b), .m_start(m_start),
    .m_o(m_o), .m_fin(m_fin)
  );

  // Behavioural multiplier: product ready, fin pulsed 9 cycles after the start edge.
  logic       fin_en = 1'b1;
  logic [7:0] ma = '0, mb = '0;
  int         mcnt = 0;
  bit         mact = 1'b0;
  always @(posedge ck) begin
    if (m_start) begin
      ma <= m_a; mb <= m_b; mcnt <= 0; mact <= 1'b1;
    end else if (mact) begin
      mcnt <= mcnt + 1;
      if (mcnt == 8) mact <= 1'b0;
    end
  end
  assign m_fin = fin_en && mact && (mcnt == 8);
  assign m_o   = 17'(ma) * 17'(mb);

  typedef struct {int id; int cyc; logic [16:0] res; logic err;} exp_t;
  exp_t exp_q[$];
  int   dlog[$];

  int n_chk = 0, n_fail = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: arbiter free -> grant first pending requester starting at ptr.
  int tcyc = 0, free_at = 0, g_c = -100, d_c = -100, cur_id = 0, mptr = 0;
  always @(posedge ck or posedge rst) begin
    int c, pick;
    exp_t e;
    if (rst) begin
      mptr = 0; free_at = 0; g_c = -100; d_c = -100;
      exp_q.delete();
    end else begin
      tcyc++;
      c = tcyc - 1;
      pick = -1;
      if (c >= free_at) begin
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && req[(mptr + k) % N]) pick = (mptr + k) % N;
        end
      end
      if (pick >= 0) begin
        e.id  = pick;
        e.err = !fin_en;
        e.res = fin_en ? 17'(a_in[8*pick +: 8]) * 17'(b_in[8*pick +: 8]) : 17'd0;
        e.cyc = c + (fin_en ? 11 : WDOG + 2);
        exp_q.push_back(e);
        g_c = c; d_c = e.cyc; free_at = e.cyc + 1; mptr = (pick + 1) % N; cur_id = pick;
      end
    end
  end

  exp_t me;
  always @(negedge ck) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(tcyc > g_c && tcyc <= d_c));
      chk("m_start", 32'(m_start), 32'(tcyc == g_c + 1));
      if (done != '0) begin
        dlog.push_back(int'(gnt_id));
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=%b, expected none (t=%0t)", done, $time);
        end else begin
          me = exp_q.pop_front();
          n_done++;
          chk("done_vec", 32'(done), 32'(1) << me.id);
          chk("gnt_id", 32'(gnt_id), me.id);
          chk("result", 32'(result), 32'(me.res));
          chk("err", 32'(err), 32'(me.err));
          chk("done_cycle", tcyc, me.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= tcyc) begin
        me = exp_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missing_done: got none, expected done for %0d at cycle %0d", me.id, me.cyc);
      end
    end
  end

  // Requester agents: drop req on own done; optionally re-raise and scramble after capture.
  bit auto_en[N], rnd_ops[N], scramble_en = 1'b0;
  int cool[N];

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0: return 8'd0;
      1: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  always @(negedge ck) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i]) begin
          req[i]  = 1'b0;
          cool[i] = rnd_ops[i] ? $urandom_range(0, 3) : 0;
        end else if (!req[i] && auto_en[i]) begin
          if (cool[i] > 0) cool[i]--;
          else begin
            if (rnd_ops[i]) begin
              a_in[8*i +: 8] = rnd8();
              b_in[8*i +: 8] = rnd8();
            end
            req[i] = 1'b1;
          end
        end else if (req[i] && scramble_en && cur_id == i && tcyc > g_c && tcyc < d_c) begin
          a_in[8*i +: 8] = 8'($urandom_range(0, 255));
          b_in[8*i +: 8] = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    a_in[8*i +: 8] = 8'(a);
    b_in[8*i +: 8] = 8'(b);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 0);
    chk({tag, "_m_a"}, 32'(m_a), 0);
    chk({tag, "_m_b"}, 32'(m_b), 0);
    chk({tag, "_m_start"}, 32'(m_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((req != '0 || exp_q.size() != 0) && n < lim) begin
      @(negedge ck);
      n++;
    end
    chk("idle_within_bound", 32'(n < lim), 1);
    @(negedge ck);
  endtask

  initial begin
    int n;
    int ord[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin
      auto_en[i] = 1'b0; rnd_ops[i] = 1'b0; cool[i] = 0;
    end
    repeat (3) @(negedge ck);
    #1 zero_checks("reset");
    @(negedge ck);
    rst = 1'b0;

    // Single request: 200 x 150.
    @(negedge ck);
    set_ops(0, 200, 150);
    req[0] = 1'b1;
    wait_idle(40);
    chk("single_result", 32'(result), 30000);
    chk("single_gnt", 32'(gnt_id), 0);
    chk("single_err", 32'(err), 0);

    // All four requesting continuously with boundary operands.
    set_ops(0, 255, 255); set_ops(1, 0, 8'h37); set_ops(2, 1, 1); set_ops(3, 16, 16);
    n = n_done;
    for (int i = 0; i < N; i++) auto_en[i] = 1'b1;
    for (int k = 0; k < 100 && n_done < n + 5; k++) @(negedge ck);
    chk("rr_five_done", 32'(n_done >= n + 5), 1);
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    wait_idle(80);

    // req[2] raised in the DONE cycle of requester 1, then 3, 0, 1 contend.
    dlog.delete();
    set_ops(1, 3, 5);
    req[1] = 1'b1;
    n = 0;
    while (!done[1] && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("done1_within_bound", 32'(n < 40), 1);
    set_ops(2, 6, 7);
    req[2] = 1'b1;
    repeat (3) @(negedge ck);
    set_ops(0, 11, 12); set_ops(1, 13, 14); set_ops(3, 15, 16);
    req[0] = 1'b1; req[1] = 1'b1; req[3] = 1'b1;
    wait_idle(80);
    chk("order_len", 32'(dlog.size()), 5);
    for (int k = 0; k < 5 && k < dlog.size(); k++) chk("grant_order", dlog[k], ord[k]);

    // Watchdog: multiplier never finishes, then recovery.
    fin_en = 1'b0;
    set_ops(1, 9, 9);
    req[1] = 1'b1;
    wait_idle(60);
    chk("wdog_err", 32'(err), 1);
    chk("wdog_result", 32'(result), 0);
    fin_en = 1'b1;
    set_ops(1, 10, 20);
    req[1] = 1'b1;
    wait_idle(40);
    chk("recover_err", 32'(err), 0);
    chk("recover_result", 32'(result), 200);

    // Asynchronous reset in RUN cycle 5.
    set_ops(2, 7, 9);
    req[2] = 1'b1;
    n = 0;
    while (!(d_c > tcyc && tcyc == g_c + 6) && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("reach_run5", 32'(n < 40), 1);
    chk("busy_before_rst", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 zero_checks("midrun_rst");
    req = '0;
    @(negedge ck);
    rst = 1'b0;
    set_ops(3, 12, 13); set_ops(1, 2, 3);
    req[3] = 1'b1; req[1] = 1'b1;
    wait_idle(60);
    chk("post_rst_gnt", 32'(gnt_id), 3);
    chk("post_rst_result", 32'(result), 156);

    // Randomized traffic with operands scrambled after capture.
    scramble_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      rnd_ops[i] = 1'b1; cool[i] = $urandom_range(0, 5); auto_en[i] = 1'b1;
    end
    repeat (800) @(negedge ck);
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    wait_idle(100);
    scramble_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
